regfile_dump: RTL

- Debug reader that walks the integer register file and streams every register out over a valid/ready interface.
- Sits beside the register file. It borrows one read port while the core is halted. The surrounding logic muxes dump_addr onto the read address whenever rd_req is high.
- The register file read is combinational: the address is driven and the data comes back in the same cycle.
- The block is the read-side counterpart to the writeback path. The debug host consumes the stream.

---
 rtl/regfile_dump_if.sv | 23 ++
 rtl/regfile_dump.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_if.sv
// Register-file read port plus the valid/ready dump stream shared by regfile_dump and its host.
interface regfile_dump_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            rd_req;
  logic [AW-1:0]   dump_addr;
  logic [XLEN-1:0] rs_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic [AW:0]     out_index;

  modport master (
    output rd_req, dump_addr, out_valid, out_data, out_index,
    input  rs_data, out_ready
  );

  modport slave (
    input  rd_req, dump_addr, out_valid, out_data, out_index,
    output rs_data, out_ready
  );
endinterface

// File: rtl/regfile_dump.sv
// Debug reader that walks the integer register file and streams each register out.
// Define REGFILE_DUMP_CHECKSUM_EN to append an XOR checksum word (index NUM_REGS).
module regfile_dump #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = 5
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           abort,
  regfile_dump_if.master bus,
  output logic           busy,
  output logic           done
);
  localparam int unsigned IW = AW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REGS - 1);
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam logic [IW-1:0] CSUM_IDX = IW'(NUM_REGS);
`endif

`ifdef REGFILE_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, FINISH} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, SEND, FINISH} state_t;
`endif

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_data_q, out_data_d;
  logic [IW-1:0]   out_index_q, out_index_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            accept;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [XLEN-1:0] acc_q, acc_d;
`endif

  assign accept        = out_valid_q && bus.out_ready;
  assign bus.rd_req    = busy_q;
  assign bus.dump_addr = idx_q[AW-1:0];
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign busy          = busy_q;
  assign done          = done_q;

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      acc_q       <= acc_d;
`endif
    end
  end

  // Next state and next output values
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    busy_d      = 1'b1;
    done_d      = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    acc_d       = acc_q;
`endif

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        idx_d  = '0;
        if (start && !abort) begin
          state_d = READ;
          busy_d  = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d   = '0;
`endif
        end
      end

      // Read data is combinational, so capture it on the single READ edge
      READ: begin
        out_data_d  = bus.rs_data;
        out_index_d = idx_q;
        out_valid_d = 1'b1;
        state_d     = SEND;
      end

      SEND: begin
        out_valid_d = 1'b1;
        if (accept) begin
          out_valid_d = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          acc_d = acc_q ^ out_data_q;
`endif
          if (idx_q == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            state_d     = CSUM;
            out_valid_d = 1'b1;
            out_data_d  = acc_d;
            out_index_d = CSUM_IDX;
`else
            state_d = FINISH;
            done_d  = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = READ;
          end
        end
      end

`ifdef REGFILE_DUMP_CHECKSUM_EN
      CSUM: begin
        out_valid_d = 1'b1;
        if (accept) begin
          out_valid_d = 1'b0;
          state_d     = FINISH;
          done_d      = 1'b1;
        end
      end
`endif

      FINISH: begin
        state_d = IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides any acceptance in the same cycle
    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      idx_d       = '0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
    end
  end
endmodule
